// File: rtl/md_pkg.sv
// Shared op/mode codes, FSM states and latency defaults for the MD issue path.
package md_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MFHI  = 4'd7,
      OP_MFLO  = 4'd8
   } md_op_e;

   typedef enum logic [1:0] {
      MODE_MULT  = 2'd0,
      MODE_MULTU = 2'd1,
      MODE_DIV   = 2'd2,
      MODE_DIVU  = 2'd3
   } md_mode_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   function automatic int md_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic md_is_exec(input logic [3:0] op);
      return (op >= OP_MULT) && (op <= OP_DIVU);
   endfunction

   function automatic logic md_is_any(input logic [3:0] op);
      return (op >= OP_MULT) && (op <= OP_MFLO);
   endfunction

   function automatic logic md_is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Load/decrement latency counter; busy while non-zero, last on the final cycle.
module md_busy_timer #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_busy,
   output logic         o_last
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_clr) begin
      if (i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_busy = (r_cnt != '0);
   assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue/hazard control in front of multdiv: start/write strobes, latency, D stall.
// Optional MD_DIV0_SKIP_EN: divide by zero is dropped instead of issued.
module md_issue_ctrl
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        d_md,
   input  logic [3:0]  e_op,
   input  logic        e_flush,
   input  logic [31:0] e_rs,
   input  logic [31:0] e_rt,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   output logic        md_start,
   output logic [1:0]  md_mode,
   output logic        md_we,
   output logic        md_a1,
   output logic [31:0] e_md_out,
   output logic        busy,
   output logic        stall_d,
   output logic        proto_err
);

   localparam int CW = $clog2(md_max(MULT_CYCLES, DIV_CYCLES) + 1);
   localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

   localparam logic [0:0] S_IDLE = ST_IDLE;
   localparam logic [0:0] S_BUSY = ST_BUSY;

   logic [0:0]    r_state;
   logic          r_perr;

   logic          w_idle;
   logic          w_exec;
   logic          w_div;
   logic          w_skip;
   logic          w_issue;
   logic          w_wr;
   logic          w_busy;
   logic          w_last;
   logic [CW-1:0] w_ld_val;
   logic [1:0]    w_mode;
   logic [31:0]   w_out;

   assign w_idle = (r_state == S_IDLE);
   assign w_exec = md_is_exec(e_op);
   assign w_div  = md_is_div(e_op);

`ifdef MD_DIV0_SKIP_EN
   // A zero divisor never reaches multdiv, so HI/LO keep their old value.
   assign w_skip = w_div & (e_rt == 32'd0);
`else
   assign w_skip = 1'b0;
`endif

   assign w_issue  = w_idle & w_exec & ~e_flush & ~w_skip;
   assign w_wr     = w_idle & ~e_flush
                   & ((e_op == OP_MTHI) | (e_op == OP_MTLO));
   assign w_ld_val = w_div ? DIV_LD : MULT_LD;

   always_comb begin
      w_mode = MODE_MULT;
      unique case (e_op)
         OP_MULTU: w_mode = MODE_MULTU;
         OP_DIV:   w_mode = MODE_DIV;
         OP_DIVU:  w_mode = MODE_DIVU;
         default:  w_mode = MODE_MULT;
      endcase
   end

   always_comb begin
      w_out = 32'd0;
      unique case (1'b1)
         (e_op == OP_MFHI): w_out = hi;
         (e_op == OP_MFLO): w_out = lo;
         default:           w_out = 32'd0;
      endcase
   end

   md_busy_timer #(
      .W (CW)
   ) u_timer (
      .i_clk      (clk),
      .i_clr      (clr),
      .i_load     (w_issue),
      .i_load_val (w_ld_val),
      .o_busy     (w_busy),
      .o_last     (w_last)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE:  if (w_issue) r_state <= S_BUSY;
            S_BUSY:  if (w_last)  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Sticky protocol error: D should never let an MD op through while busy.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_perr <= 1'b0;
      end else if (w_busy & md_is_any(e_op)) begin
         r_perr <= 1'b1;
      end
   end

   assign md_a      = e_rs;
   assign md_b      = e_rt;
   assign md_mode   = w_mode;
   assign md_a1     = (e_op == OP_MTHI);
   assign md_start  = w_issue & ~clr;
   assign md_we     = w_wr & ~clr;
   assign e_md_out  = w_out;
   assign busy      = w_busy;
   assign stall_d   = d_md & (md_start | w_busy) & ~clr;
   assign proto_err = r_perr;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed + random bench for md_issue_ctrl against a cycle-count reference model.
module tb_md_issue_ctrl;

   logic        clk = 1'b0;
   logic        clr;
   logic        d_md;
   logic [3:0]  e_op;
   logic        e_flush;
   logic [31:0] e_rs;
   logic [31:0] e_rt;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        md_start;
   logic [1:0]  md_mode;
   logic        md_we;
   logic        md_a1;
   logic [31:0] e_md_out;
   logic        busy;
   logic        stall_d;
   logic        proto_err;

   int n_vec = 0;
   int n_err = 0;

   // reference model: remaining busy cycles, sticky error, HI/LO contents
   int          m_left = 0;
   bit          m_perr = 1'b0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   localparam int LAT_MULT = 5;
   localparam int LAT_DIV  = 10;

   md_issue_ctrl dut (
      .clk       (clk),
      .clr       (clr),
      .d_md      (d_md),
      .e_op      (e_op),
      .e_flush   (e_flush),
      .e_rs      (e_rs),
      .e_rt      (e_rt),
      .hi        (hi),
      .lo        (lo),
      .md_a      (md_a),
      .md_b      (md_b),
      .md_start  (md_start),
      .md_mode   (md_mode),
      .md_we     (md_we),
      .md_a1     (md_a1),
      .e_md_out  (e_md_out),
      .busy      (busy),
      .stall_d   (stall_d),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic calc(input int op, input logic [31:0] rs,
                       input logic [31:0] rt,
                       output logic [31:0] rh, output logic [31:0] rl);
      longint sa;
      longint sb;
      longint q;
      longint r;
      logic [63:0] p;
      sa = longint'($signed(rs));
      sb = longint'($signed(rt));
      rh = 32'd0;
      rl = 32'd0;
      case (op)
         1: begin
            p = 64'(sa * sb);
            rh = p[63:32];
            rl = p[31:0];
         end
         2: begin
            p = {32'd0, rs} * {32'd0, rt};
            rh = p[63:32];
            rl = p[31:0];
         end
         3: begin
            if (rt == 32'd0) begin
               rh = rs;
               rl = 32'hFFFF_FFFF;
            end else begin
               q = sa / sb;
               r = sa % sb;
               rh = r[31:0];
               rl = q[31:0];
            end
         end
         default: begin
            if (rt == 32'd0) begin
               rh = rs;
               rl = 32'hFFFF_FFFF;
            end else begin
               rh = rs % rt;
               rl = rs / rt;
            end
         end
      endcase
   endtask

   // One E-stage cycle: drive, check combinational + state outputs, clock, update model.
   task automatic step(input int op, input logic [31:0] rs,
                       input logic [31:0] rt, input bit fl, input bit dm);
      bit bz;
      bit skip;
      bit iss;
      bit we;
      logic [1:0]  x_mode;
      logic [31:0] x_out;
      logic [31:0] rh;
      logic [31:0] rl;
      e_op    = 4'(op);
      e_rs    = rs;
      e_rt    = rt;
      e_flush = fl;
      d_md    = dm;
      #3;
      bz = (m_left > 0);
`ifdef MD_DIV0_SKIP_EN
      skip = (op == 3 || op == 4) && (rt == 32'd0);
`else
      skip = 1'b0;
`endif
      iss    = !bz && op >= 1 && op <= 4 && !fl && !skip;
      we     = !bz && (op == 5 || op == 6) && !fl;
      x_mode = (op >= 1 && op <= 4) ? 2'(op - 1) : 2'd0;
      x_out  = (op == 7) ? m_hi : (op == 8) ? m_lo : 32'd0;
      chk("md_a", md_a, rs);
      chk("md_b", md_b, rt);
      chk("md_start", 32'(md_start), 32'(iss));
      chk("md_mode", 32'(md_mode), 32'(x_mode));
      chk("md_we", 32'(md_we), 32'(we));
      chk("md_a1", 32'(md_a1), 32'(op == 5));
      chk("e_md_out", e_md_out, x_out);
      chk("busy", 32'(busy), 32'(bz));
      chk("stall_d", 32'(stall_d), 32'(dm && (iss || bz)));
      chk("proto_err", 32'(proto_err), 32'(m_perr));
      @(posedge clk);
      #1;
      if (bz) begin
         m_left--;
         if (op >= 1 && op <= 8) m_perr = 1'b1;
      end
      if (iss) begin
         m_left = (op >= 3) ? LAT_DIV : LAT_MULT;
         calc(op, rs, rt, rh, rl);
         m_hi = rh;
         m_lo = rl;
      end
      if (we) begin
         if (op == 5) m_hi = rs;
         else m_lo = rs;
      end
      hi = m_hi;
      lo = m_lo;
   endtask

   task automatic idle(input int n, input bit dm);
      for (int i = 0; i < n; i++) step(0, 32'd0, 32'd0, 1'b0, dm);
   endtask

   // Asynchronous clear mid-cycle, with strobe-producing inputs present.
   task automatic async_clr();
      e_op = 4'd1;
      d_md = 1'b1;
      e_flush = 1'b0;
      #1;
      clr = 1'b1;
      #1;
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_stall", 32'(stall_d), 32'd0);
      chk("clr_start", 32'(md_start), 32'd0);
      chk("clr_perr", 32'(proto_err), 32'd0);
      e_op = 4'd5;
      #1;
      chk("clr_we", 32'(md_we), 32'd0);
      m_left = 0;
      m_perr = 1'b0;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      clr = 1'b1;
      d_md = 1'b1;
      e_op = 4'd1;
      e_flush = 1'b0;
      e_rs = 32'd0;
      e_rt = 32'd0;
      hi = 32'd0;
      lo = 32'd0;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(md_start), 32'd0);
      chk("rst_stall", 32'(stall_d), 32'd0);
      chk("rst_perr", 32'(proto_err), 32'd0);
      e_op = 4'd6;
      #1;
      chk("rst_we", 32'(md_we), 32'd0);
      @(posedge clk);
      #1;
      clr = 1'b0;

      // DIVU 3/2 with D stalled, then read back quotient/remainder
      step(4, 32'd3, 32'd2, 1'b0, 1'b1);
      idle(10, 1'b1);
      idle(1, 1'b1);
      step(8, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("divu_lo", lo, 32'd1);
      step(7, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("divu_hi", hi, 32'd1);

      // signed MULT -7*3
      step(1, -32'sd7, 32'd3, 1'b0, 1'b1);
      idle(6, 1'b0);
      step(8, 32'd0, 32'd0, 1'b0, 1'b0);
      step(7, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("mult_lo", lo, 32'hFFFF_FFEB);
      chk("mult_hi", hi, 32'hFFFF_FFFF);

      // MTLO then MFLO next cycle; flushed MTHI must not write
      step(6, 32'd15, 32'd0, 1'b0, 1'b0);
      step(8, 32'd0, 32'd0, 1'b0, 1'b0);
      step(5, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
      step(7, 32'd0, 32'd0, 1'b0, 1'b0);

      // divide by zero
      step(3, 32'd9, 32'd0, 1'b0, 1'b1);
      idle(11, 1'b1);
      step(8, 32'd0, 32'd0, 1'b0, 1'b0);

      // flush during busy does not abort; MD op while busy is an error
      step(2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
      step(0, 32'd0, 32'd0, 1'b1, 1'b1);
      step(7, 32'd0, 32'd0, 1'b0, 1'b1);
      step(1, 32'd4, 32'd4, 1'b0, 1'b1);
      idle(5, 1'b1);
      step(7, 32'd0, 32'd0, 1'b0, 1'b0);

      // clear during an in-flight divide
      step(3, 32'd100, 32'd7, 1'b0, 1'b1);
      idle(3, 1'b1);
      async_clr();
      idle(2, 1'b1);

      for (int i = 0; i < 400; i++) begin
         int op;
         logic [31:0] rs;
         logic [31:0] rt;
         op = int'($urandom_range(0, 8));
         rs = $urandom;
         rt = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rs = 32'($urandom_range(0, 20)) - 32'd10;
         step(op, rs, rt, ($urandom_range(0, 7) == 0), 1'($urandom));
         if (i == 200) async_clr();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
